scr1_pipe_mprf_sp: RTL and testbench
====================================

Name: scr1_pipe_mprf_sp

Overview:
- Parametrised multi-port register file built on a single-port synchronous SRAM macro (OpenRAM-style, active-low csb/web).
- Replaces the flop-based MPRF between EXU and the SRAM: two logical read ports and one write port are serialised onto one physical port.
- Adds a read request/valid handshake, write acknowledge, a hardwired-zero register option and zero-initialisation after reset.

Parameters:
- XLEN, 32, data width of each register.
- AWIDTH, 5, register address width; depth = 2**AWIDTH.
- SRAM_RD_LAT, 1, SRAM read latency in cycles (1..2).
- ZERO_REG, 1, 1 = address 0 reads 0 and ignores writes.
- INIT_ZERO, 1, 1 = write 0 to every entry after reset.

Ports:
- clk  in  1  pipeline clock; the only clock.
- rst  in  1  reset; synchronous, active-high.
- rd_req_i  in  1  read request.
- rd_rdy_o  out  1  read request accepted when rd_req_i & rd_rdy_o.
- rd_use_rs1_i / rd_use_rs2_i  in  1 each  operand needed.
- rd_rs1_addr_i / rd_rs2_addr_i  in  AWIDTH each  read addresses.
- rd_vld_o  out  1  one-cycle pulse: rs1/rs2 data valid.
- rs1_data_o / rs2_data_o  out  XLEN each  read data; registered, held until next rd_vld_o.
- wr_req_i  in  1  write request; held with addr/data until acked.
- wr_addr_i  in  AWIDTH  write address.
- wr_data_i  in  XLEN  write data.
- wr_ack_o  out  1  write performed this cycle.
- init_done_o  out  1  initialisation complete; sticky until rst.
- sram_csb_o  out  1  SRAM chip select, active-low.
- sram_web_o  out  1  SRAM write enable, active-low.
- sram_addr_o  out  AWIDTH  SRAM address.
- sram_din_o  out  XLEN  SRAM write data.
- sram_dout_i  in  XLEN  SRAM read data.

Behaviour:
- Reset (rst high at a clk edge): FSM goes to INIT (INIT_ZERO=1) or READY (INIT_ZERO=0). In-flight reads and captured data are discarded.
- While rst is high, all outputs are 0, except sram_csb_o=1 and sram_web_o=1.
- A mid-operation reset aborts the transaction with no rd_vld_o pulse.
- INIT state:
  - From the first cycle after rst falls, a counter issues one zero-write per cycle to addresses 0..2**AWIDTH-1.
  - init_done_o rises the cycle after the last write (2**AWIDTH+1 cycles after reset release).
  - rd_rdy_o=0 and wr_ack_o=0 during INIT.
  - INIT_ZERO=0: init_done_o rises the first cycle after reset release.
- Per-request access count:
  - An operand needs an SRAM access iff use=1 and not (ZERO_REG and addr==0). An operand that needs no access returns 0.
  - If both operands need access and rs1_addr==rs2_addr, one access serves both.
- Read FSM (READY, ISSUE, DRAIN, VALID):
  - rd_rdy_o = init_done_o & (state READY or VALID); back-to-back requests are allowed.
  - After acceptance in cycle T, accesses are issued from T+1, one per free SRAM cycle, rs1 before rs2.
  - Data of an access issued in cycle C is captured from sram_dout_i at C+SRAM_RD_LAT.
  - rd_vld_o pulses the cycle after the last capture.
  - Zero accesses needed: rd_vld_o at T+1.
- Write port:
  - Writes have priority over read accesses for the SRAM slot.
  - wr_ack_o is combinational, high in the cycle the write is driven (csb=0, web=0).
  - With ZERO_REG=1 a write to address 0 acks in its first eligible cycle with no SRAM access.
  - A write may issue while read data is still in flight; the SRAM is pipelined.
- Ordering:
  - A read access returns the value as of its issue cycle.
  - A write acked before a read access issues is visible to that access.
- SRAM idle: csb=1, web=1; addr and din hold their previous values.
- Never more than one SRAM access per cycle.

Test Plan:
- Reset, INIT_ZERO=1, AWIDTH=5 -> 32 consecutive zero-writes to addresses 0..31; init_done_o rises on cycle 33; a following read of x5 returns 0.
- Write x3=0xDEADBEEF, then read rs1=x3, rs2=x4 (x4=0x12345678), SRAM_RD_LAT=1, accept at T -> accesses at T+1 and T+2; rd_vld_o at T+4; data 0xDEADBEEF / 0x12345678.
- Read rs1=rs2=x7 -> single SRAM access; both outputs equal; rd_vld_o at T+3.
- ZERO_REG=1: write x0=0xFFFFFFFF -> wr_ack_o with sram_csb_o=1; then read rs1=x0, use_rs2=0 -> rd_vld_o at T+1, data 0.
- wr_req_i held high through a read of the same address at T -> write issues at T+1 with wr_ack_o; read access slips to T+2 and returns the new value.
- rst asserted the cycle after read acceptance -> no rd_vld_o; outputs go to reset values; INIT restarts.

Source files
------------

// File: rtl/scr1_pipe_mprf_sp.sv
// Multi-port register file on a single-port synchronous SRAM.
// Two logical read ports and one write port share one physical SRAM port.
// Writes take the SRAM slot first. Read operands are fetched one access per
// free cycle, with rs1 before rs2. Returned data is tracked through a tag
// pipeline that matches the SRAM read latency.
//
// Handshakes:
//   read : a request is accepted in the cycle where rd_req_i & rd_rdy_o.
//          The addresses and use flags are sampled in that cycle. rd_vld_o is
//          a one-cycle pulse. rs1_data_o/rs2_data_o hold their value until the
//          next rd_vld_o.
//   write: wr_req_i, wr_addr_i and wr_data_i stay stable until the cycle where
//          wr_ack_o is high. That cycle performs the write.
module scr1_pipe_mprf_sp #(
  parameter int XLEN        = 32,
  parameter int AWIDTH      = 5,
  parameter int SRAM_RD_LAT = 1,
  parameter int ZERO_REG    = 1,
  parameter int INIT_ZERO   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req_i,
  output logic              rd_rdy_o,
  input  logic              rd_use_rs1_i,
  input  logic              rd_use_rs2_i,
  input  logic [AWIDTH-1:0] rd_rs1_addr_i,
  input  logic [AWIDTH-1:0] rd_rs2_addr_i,
  output logic              rd_vld_o,
  output logic [XLEN-1:0]   rs1_data_o,
  output logic [XLEN-1:0]   rs2_data_o,
  input  logic              wr_req_i,
  input  logic [AWIDTH-1:0] wr_addr_i,
  input  logic [XLEN-1:0]   wr_data_i,
  output logic              wr_ack_o,
  output logic              init_done_o,
  output logic              sram_csb_o,
  output logic              sram_web_o,
  output logic [AWIDTH-1:0] sram_addr_o,
  output logic [XLEN-1:0]   sram_din_o,
  input  logic [XLEN-1:0]   sram_dout_i
);

  localparam bit ZR = (ZERO_REG != 0);
  localparam bit IZ = (INIT_ZERO != 0);

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_READY = 3'd1,
    ST_ISSUE = 3'd2,
    ST_DRAIN = 3'd3,
    ST_VALID = 3'd4
  } state_t;

  state_t                 state_q, state_nxt;
  logic                   done_q;
  logic [AWIDTH-1:0]      init_cnt_q;
  logic [AWIDTH-1:0]      rs1_addr_q, rs2_addr_q;
  logic                   pend1_q, pend2_q, merge_q;
  logic [XLEN-1:0]        cap1_q, cap2_q, out1_q, out2_q;
  logic [SRAM_RD_LAT-1:0] tag_vld_q, tag_r1_q, tag_r2_q;
  logic [AWIDTH-1:0]      addr_q, addr_nxt;
  logic [XLEN-1:0]        din_q, din_nxt;

  logic act, rd_accept, need1, need2, same_addr;
  logic init_wr, wr_ack, wr_sram, rd_issue;
  logic cap_now, early_busy, last_cap;

  // Control decode. Every externally visible strobe is gated while reset is high.
  always_comb begin
    act       = ~rst;
    rd_accept = act & done_q & ((state_q == ST_READY) | (state_q == ST_VALID)) & rd_req_i;
    need1     = rd_use_rs1_i & ~(ZR & (rd_rs1_addr_i == '0));
    need2     = rd_use_rs2_i & ~(ZR & (rd_rs2_addr_i == '0));
    same_addr = (rd_rs1_addr_i == rd_rs2_addr_i);
    init_wr   = act & (state_q == ST_INIT);
    wr_ack    = act & done_q & (state_q != ST_INIT) & wr_req_i;
    wr_sram   = wr_ack & ~(ZR & (wr_addr_i == '0));
    rd_issue  = act & (state_q == ST_ISSUE) & ~wr_sram & (pend1_q | pend2_q);
    cap_now   = tag_vld_q[SRAM_RD_LAT-1];
    last_cap  = (state_q == ST_DRAIN) & cap_now & ~early_busy;
  end

  // Detect whether any access is still in flight ahead of the output stage.
  always_comb begin
    early_busy = 1'b0;
    for (int i = 0; i < SRAM_RD_LAT - 1; i++) early_busy = early_busy | tag_vld_q[i];
  end

  // Next-state logic for the init/read sequencer.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_INIT:  if (init_cnt_q == {AWIDTH{1'b1}}) state_nxt = ST_READY;
      ST_READY,
      ST_VALID: begin
        if (rd_accept) state_nxt = (need1 | need2) ? ST_ISSUE : ST_VALID;
        else           state_nxt = ST_READY;
      end
      ST_ISSUE: if (rd_issue && !(pend1_q && pend2_q)) state_nxt = ST_DRAIN;
      ST_DRAIN: if (last_cap) state_nxt = ST_VALID;
      default:  state_nxt = ST_READY;
    endcase
  end

  // SRAM address and data. Both hold their previous values when the SRAM is idle.
  always_comb begin
    addr_nxt = addr_q;
    din_nxt  = din_q;
    if (init_wr) begin
      addr_nxt = init_cnt_q;
      din_nxt  = '0;
    end else if (wr_sram) begin
      addr_nxt = wr_addr_i;
      din_nxt  = wr_data_i;
    end else if (rd_issue) begin
      addr_nxt = pend1_q ? rs1_addr_q : rs2_addr_q;
    end
  end

  // Sequencer state, init counter, pending operands, tag pipeline and data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IZ ? ST_INIT : ST_READY;
      done_q     <= ~IZ;
      init_cnt_q <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      pend1_q    <= 1'b0;
      pend2_q    <= 1'b0;
      merge_q    <= 1'b0;
      cap1_q     <= '0;
      cap2_q     <= '0;
      out1_q     <= '0;
      out2_q     <= '0;
      tag_vld_q  <= '0;
      tag_r1_q   <= '0;
      tag_r2_q   <= '0;
      addr_q     <= '0;
      din_q      <= '0;
    end else begin
      state_q <= state_nxt;
      addr_q  <= addr_nxt;
      din_q   <= din_nxt;
      if (init_wr) begin
        init_cnt_q <= init_cnt_q + AWIDTH'(1);
        if (init_cnt_q == {AWIDTH{1'b1}}) done_q <= 1'b1;
      end
      // Tag pipeline: the stage SRAM_RD_LAT-1 entry lines up with sram_dout_i.
      tag_vld_q[0] <= rd_issue;
      tag_r1_q[0]  <= rd_issue & pend1_q;
      tag_r2_q[0]  <= rd_issue & (pend1_q ? merge_q : 1'b1);
      for (int i = 1; i < SRAM_RD_LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_r1_q[i]  <= tag_r1_q[i-1];
        tag_r2_q[i]  <= tag_r2_q[i-1];
      end
      if (cap_now) begin
        if (tag_r1_q[SRAM_RD_LAT-1]) cap1_q <= sram_dout_i;
        if (tag_r2_q[SRAM_RD_LAT-1]) cap2_q <= sram_dout_i;
      end
      if (last_cap) begin
        out1_q <= tag_r1_q[SRAM_RD_LAT-1] ? sram_dout_i : cap1_q;
        out2_q <= tag_r2_q[SRAM_RD_LAT-1] ? sram_dout_i : cap2_q;
      end
      if (rd_issue) begin
        if (pend1_q) pend1_q <= 1'b0;
        else         pend2_q <= 1'b0;
      end
      // An operand that needs no access reads as zero, so both capture registers start cleared.
      if (rd_accept) begin
        rs1_addr_q <= rd_rs1_addr_i;
        rs2_addr_q <= rd_rs2_addr_i;
        pend1_q    <= need1;
        pend2_q    <= need2 & ~(need1 & same_addr);
        merge_q    <= need1 & need2 & same_addr;
        cap1_q     <= '0;
        cap2_q     <= '0;
        if (!(need1 || need2)) begin
          out1_q <= '0;
          out2_q <= '0;
        end
      end
    end
  end

  // Output drive. All outputs are forced to their reset values while rst is high.
  always_comb begin
    rd_rdy_o    = act & done_q & ((state_q == ST_READY) | (state_q == ST_VALID));
    rd_vld_o    = act & (state_q == ST_VALID);
    rs1_data_o  = act ? out1_q : '0;
    rs2_data_o  = act ? out2_q : '0;
    wr_ack_o    = wr_ack;
    init_done_o = act & done_q;
    sram_csb_o  = ~(init_wr | wr_sram | rd_issue);
    sram_web_o  = ~(init_wr | wr_sram);
    sram_addr_o = act ? addr_nxt : '0;
    sram_din_o  = act ? din_nxt : '0;
  end

endmodule

// File: tb/tb_scr1_pipe_mprf_sp.sv
// Bench for scr1_pipe_mprf_sp with default parameters.
// An architectural register array gives the expected read data.
// A small SRAM stand-in models the macro with a configurable read latency.
module tb_scr1_pipe_mprf_sp;

  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int LAT   = 1;
  localparam int DEPTH = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            rd_req_i = 1'b0, rd_rdy_o;
  logic            rd_use_rs1_i = 1'b0, rd_use_rs2_i = 1'b0;
  logic [AW-1:0]   rd_rs1_addr_i = '0, rd_rs2_addr_i = '0;
  logic            rd_vld_o;
  logic [XLEN-1:0] rs1_data_o, rs2_data_o;
  logic            wr_req_i = 1'b0;
  logic [AW-1:0]   wr_addr_i = '0;
  logic [XLEN-1:0] wr_data_i = '0;
  logic            wr_ack_o, init_done_o;
  logic            sram_csb_o, sram_web_o;
  logic [AW-1:0]   sram_addr_o;
  logic [XLEN-1:0] sram_din_o, sram_dout_i;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int last_ack_cyc;

  logic [XLEN-1:0]   ref_mem  [DEPTH];
  logic [XLEN-1:0]   sram_mem [DEPTH];
  logic [XLEN-1:0]   rpipe    [2];
  int                acc_cyc_q[$];
  int                acc_addr_q[$];
  logic [2*XLEN-1:0] exp_q[$];

  scr1_pipe_mprf_sp #(.XLEN(XLEN), .AWIDTH(AW), .SRAM_RD_LAT(LAT), .ZERO_REG(1), .INIT_ZERO(1)) dut (
    .clk(clk), .rst(rst),
    .rd_req_i(rd_req_i), .rd_rdy_o(rd_rdy_o),
    .rd_use_rs1_i(rd_use_rs1_i), .rd_use_rs2_i(rd_use_rs2_i),
    .rd_rs1_addr_i(rd_rs1_addr_i), .rd_rs2_addr_i(rd_rs2_addr_i),
    .rd_vld_o(rd_vld_o), .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
    .wr_req_i(wr_req_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .wr_ack_o(wr_ack_o),
    .init_done_o(init_done_o),
    .sram_csb_o(sram_csb_o), .sram_web_o(sram_web_o), .sram_addr_o(sram_addr_o),
    .sram_din_o(sram_din_o), .sram_dout_i(sram_dout_i)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM stand-in. Data read in cycle C appears in cycle C+LAT. Idle cycles return noise.
  always @(posedge clk) begin
    if (!sram_csb_o && !sram_web_o) sram_mem[sram_addr_o] <= sram_din_o;
    if (!sram_csb_o && sram_web_o)  rpipe[0] <= sram_mem[sram_addr_o];
    else                            rpipe[0] <= $urandom;
    rpipe[1] <= rpipe[0];
  end
  assign sram_dout_i = rpipe[LAT-1];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model of what the register file should return.
  function automatic logic [XLEN-1:0] model_rd(int a, bit u);
    if (!u || a == 0) return '0;
    return ref_mem[a];
  endfunction

  function automatic int model_acc(int a1, bit u1, int a2, bit u2);
    bit n1, n2;
    n1 = u1 && (a1 != 0);
    n2 = u2 && (a2 != 0);
    if (n1 && n2 && a1 == a2) return 1;
    return int'(n1) + int'(n2);
  endfunction

  function automatic int model_lat(int n);
    return (n == 0) ? 1 : n + LAT + 1;
  endfunction

  // Driver tasks.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int a, input logic [XLEN-1:0] d, output int ack_cyc, output logic ack_csb);
    ack_cyc = -1;
    ack_csb = 1'bx;
    wr_req_i = 1'b1; wr_addr_i = a[AW-1:0]; wr_data_i = d;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (wr_ack_o === 1'b1) begin
        ack_cyc = cyc;
        ack_csb = sram_csb_o;
        break;
      end
      tick();
    end
    tick();
    wr_req_i = 1'b0;
    if (ack_cyc < 0) begin
      n_cmp++; n_err++;
      $display("FAIL write_timeout: addr %0d not acked within 40 cycles", a);
    end else if (a != 0) begin
      ref_mem[a] = d;
    end
  endtask

  task automatic do_read(input int a1, input bit u1, input int a2, input bit u2,
                         input int wr_at, input int wr_a, input logic [XLEN-1:0] wr_d,
                         output int t_acc, output int t_vld,
                         output logic [XLEN-1:0] d1, output logic [XLEN-1:0] d2);
    bit acked, wr_on;
    t_acc = -1; t_vld = -1; d1 = '0; d2 = '0; acked = 0; wr_on = 0;
    acc_cyc_q.delete(); acc_addr_q.delete(); last_ack_cyc = -1;
    rd_req_i = 1'b1; rd_use_rs1_i = u1; rd_use_rs2_i = u2;
    rd_rs1_addr_i = a1[AW-1:0]; rd_rs2_addr_i = a2[AW-1:0];
    for (int i = 0; i < 40; i++) begin
      #1;
      if (rd_rdy_o === 1'b1) begin
        t_acc = cyc;
        break;
      end
      tick();
    end
    tick();
    rd_req_i = 1'b0;
    if (t_acc < 0) begin
      n_cmp++; n_err++;
      $display("FAIL read_accept_timeout: rd_rdy_o never high");
      return;
    end
    for (int i = 0; i < 20; i++) begin
      if (wr_at > 0 && cyc == t_acc + wr_at && !acked) begin
        wr_req_i = 1'b1; wr_addr_i = wr_a[AW-1:0]; wr_data_i = wr_d; wr_on = 1;
      end
      #1;
      if (sram_csb_o === 1'b0 && sram_web_o === 1'b1) begin
        acc_cyc_q.push_back(cyc);
        acc_addr_q.push_back(int'(sram_addr_o));
      end
      if (wr_on && wr_ack_o === 1'b1) begin
        acked = 1; wr_on = 0; last_ack_cyc = cyc;
        if (wr_a != 0) ref_mem[wr_a] = wr_d;
      end
      if (rd_vld_o === 1'b1) begin
        t_vld = cyc; d1 = rs1_data_o; d2 = rs2_data_o;
      end
      tick();
      if (!wr_on) wr_req_i = 1'b0;
      if (t_vld >= 0) break;
    end
    wr_req_i = 1'b0;
    if (t_vld < 0) begin
      n_cmp++; n_err++;
      $display("FAIL read_vld_timeout: no rd_vld_o within 20 cycles of acceptance");
    end
  endtask

  // Scenarios.
  task automatic test_reset();
    rst = 1'b1; rd_req_i = 1'b1; wr_req_i = 1'b1; wr_addr_i = 5'd3; wr_data_i = 32'h55;
    tick(); tick();
    #1;
    n_cmp++;
    if ({rd_rdy_o, rd_vld_o, wr_ack_o, init_done_o} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_ctrl: got rdy/vld/ack/done=%b required 0000", {rd_rdy_o, rd_vld_o, wr_ack_o, init_done_o});
    end
    n_cmp++;
    if ({sram_csb_o, sram_web_o} !== 2'b11) begin
      n_err++;
      $display("FAIL reset_sram_ctrl: got csb/web=%b required 11", {sram_csb_o, sram_web_o});
    end
    n_cmp++;
    if ({sram_addr_o, sram_din_o, rs1_data_o, rs2_data_o} !== '0) begin
      n_err++;
      $display("FAIL reset_data: got addr=%h din=%h rs1=%h rs2=%h required all 0", sram_addr_o, sram_din_o, rs1_data_o, rs2_data_o);
    end
    rd_req_i = 1'b0; wr_req_i = 1'b0;
  endtask

  task automatic test_init();
    int t_acc, t_vld;
    logic [XLEN-1:0] d1, d2;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i > 0) tick();
      wr_req_i = (i < 8); wr_addr_i = 5'd5; wr_data_i = 32'h77;
      #1;
      n_cmp++;
      if ({sram_csb_o, sram_web_o, sram_addr_o, sram_din_o, init_done_o, rd_rdy_o, wr_ack_o} !==
          {1'b0, 1'b0, i[AW-1:0], {XLEN{1'b0}}, 3'b000}) begin
        n_err++;
        $display("FAIL init_write_%0d: got csb=%b web=%b addr=%0d din=%h done=%b rdy=%b ack=%b required 0 0 %0d 0 0 0 0",
                 i, sram_csb_o, sram_web_o, sram_addr_o, sram_din_o, init_done_o, rd_rdy_o, wr_ack_o, i);
      end
    end
    tick();
    wr_req_i = 1'b0;
    #1;
    n_cmp++;
    if ({init_done_o, rd_rdy_o} !== 2'b11) begin
      n_err++;
      $display("FAIL init_done_cycle33: got done/rdy=%b required 11", {init_done_o, rd_rdy_o});
    end
    tick();
    do_read(5, 1, 0, 0, 0, 0, '0, t_acc, t_vld, d1, d2);
    n_cmp++;
    if ({d1, d2} !== {model_rd(5, 1), model_rd(0, 0)}) begin
      n_err++;
      $display("FAIL init_read_x5: got %h/%h required %h/%h", d1, d2, model_rd(5, 1), model_rd(0, 0));
    end
  endtask

  task automatic test_write_read();
    int t_acc, t_vld, ack_cyc;
    logic ack_csb;
    logic [XLEN-1:0] d1, d2;
    do_write(3, 32'hDEADBEEF, ack_cyc, ack_csb);
    do_write(4, 32'h12345678, ack_cyc, ack_csb);
    do_read(3, 1, 4, 1, 0, 0, '0, t_acc, t_vld, d1, d2);
    n_cmp++;
    if (acc_cyc_q.size() != 2 || acc_cyc_q[0] != t_acc + 1 || acc_cyc_q[1] != t_acc + 2 ||
        acc_addr_q[0] != 3 || acc_addr_q[1] != 4) begin
      n_err++;
      $display("FAIL rd2_accesses: got %0d accesses (first at T+%0d) required 2 at T+1,T+2 to x3,x4",
               acc_cyc_q.size(), (acc_cyc_q.size() > 0) ? acc_cyc_q[0] - t_acc : -1);
    end
    n_cmp++;
    if (t_vld - t_acc != model_lat(model_acc(3, 1, 4, 1))) begin
      n_err++;
      $display("FAIL rd2_latency: got vld at T+%0d required T+%0d", t_vld - t_acc, model_lat(model_acc(3, 1, 4, 1)));
    end
    n_cmp++;
    if ({d1, d2} !== {model_rd(3, 1), model_rd(4, 1)}) begin
      n_err++;
      $display("FAIL rd2_data: got %h/%h required %h/%h", d1, d2, model_rd(3, 1), model_rd(4, 1));
    end
    #1;
    n_cmp++;
    if (rd_vld_o !== 1'b0 || rs1_data_o !== model_rd(3, 1)) begin
      n_err++;
      $display("FAIL rd2_pulse_hold: got vld=%b rs1=%h required vld=0 rs1=%h", rd_vld_o, rs1_data_o, model_rd(3, 1));
    end
  endtask

  task automatic test_same_addr();
    int t_acc, t_vld, ack_cyc;
    logic ack_csb;
    logic [XLEN-1:0] d1, d2, v;
    v = $urandom;
    tick();
    do_write(7, v, ack_cyc, ack_csb);
    do_read(7, 1, 7, 1, 0, 0, '0, t_acc, t_vld, d1, d2);
    n_cmp++;
    if (acc_cyc_q.size() != model_acc(7, 1, 7, 1)) begin
      n_err++;
      $display("FAIL same_addr_accesses: got %0d required %0d", acc_cyc_q.size(), model_acc(7, 1, 7, 1));
    end
    n_cmp++;
    if (t_vld - t_acc != 3) begin
      n_err++;
      $display("FAIL same_addr_latency: got T+%0d required T+3", t_vld - t_acc);
    end
    n_cmp++;
    if (d1 !== v || d2 !== v) begin
      n_err++;
      $display("FAIL same_addr_data: got %h/%h required %h/%h", d1, d2, v, v);
    end
  endtask

  task automatic test_zero_reg();
    int t_acc, t_vld, ack_cyc;
    logic ack_csb;
    logic [XLEN-1:0] d1, d2;
    do_write(0, 32'hFFFFFFFF, ack_cyc, ack_csb);
    n_cmp++;
    if (ack_cyc < 0 || ack_csb !== 1'b1) begin
      n_err++;
      $display("FAIL zero_wr_no_sram: got ack_cycle=%0d csb=%b required ack with csb=1", ack_cyc, ack_csb);
    end
    do_read(0, 1, 9, 0, 0, 0, '0, t_acc, t_vld, d1, d2);
    n_cmp++;
    if (t_vld - t_acc != 1 || acc_cyc_q.size() != 0) begin
      n_err++;
      $display("FAIL zero_rd_latency: got vld at T+%0d with %0d accesses required T+1 with 0", t_vld - t_acc, acc_cyc_q.size());
    end
    n_cmp++;
    if ({d1, d2} !== '0) begin
      n_err++;
      $display("FAIL zero_rd_data: got %h/%h required 0/0", d1, d2);
    end
  endtask

  task automatic test_write_priority();
    int t_acc, t_vld, ack_cyc;
    logic ack_csb;
    logic [XLEN-1:0] d1, d2;
    do_write(9, 32'h11111111, ack_cyc, ack_csb);
    do_read(9, 1, 0, 0, 1, 9, 32'hCAFEF00D, t_acc, t_vld, d1, d2);
    n_cmp++;
    if (last_ack_cyc != t_acc + 1 || acc_cyc_q.size() != 1 || acc_cyc_q[0] != t_acc + 2) begin
      n_err++;
      $display("FAIL prio_order: got ack at T+%0d read at T+%0d required ack T+1 read T+2",
               last_ack_cyc - t_acc, (acc_cyc_q.size() > 0) ? acc_cyc_q[0] - t_acc : -1);
    end
    n_cmp++;
    if (t_vld - t_acc != 4) begin
      n_err++;
      $display("FAIL prio_latency: got vld at T+%0d required T+4", t_vld - t_acc);
    end
    n_cmp++;
    if (d1 !== 32'hCAFEF00D) begin
      n_err++;
      $display("FAIL prio_data: got %h required cafef00d", d1);
    end
  endtask

  task automatic test_back_to_back();
    int ack_cyc, accepted, b2b, a1, a2;
    bit u1, u2;
    logic ack_csb;
    logic [2*XLEN-1:0] e;
    for (int a = 1; a < DEPTH; a++) do_write(a, $urandom, ack_cyc, ack_csb);
    accepted = 0; b2b = 0; a1 = 0; a2 = 0; u1 = 0; u2 = 0;
    for (int c = 0; c < 300; c++) begin
      if (accepted < 12) begin
        a1 = $urandom_range(0, DEPTH - 1); a2 = $urandom_range(0, DEPTH - 1);
        u1 = ($urandom_range(0, 3) != 0);  u2 = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 3) == 0) a2 = a1;
        rd_req_i = 1'b1; rd_use_rs1_i = u1; rd_use_rs2_i = u2;
        rd_rs1_addr_i = a1[AW-1:0]; rd_rs2_addr_i = a2[AW-1:0];
      end else begin
        rd_req_i = 1'b0;
      end
      #1;
      if (rd_vld_o === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL b2b_unexpected_vld: got rd_vld_o with no read outstanding");
        end else begin
          e = exp_q.pop_front();
          if ({rs1_data_o, rs2_data_o} !== e) begin
            n_err++;
            $display("FAIL b2b_data: got %h/%h required %h/%h", rs1_data_o, rs2_data_o, e[2*XLEN-1:XLEN], e[XLEN-1:0]);
          end
        end
      end
      if (rd_req_i && rd_rdy_o === 1'b1) begin
        if (rd_vld_o === 1'b1) b2b++;
        exp_q.push_back({model_rd(a1, u1), model_rd(a2, u2)});
        accepted++;
      end
      tick();
      if (accepted == 12 && exp_q.size() == 0) break;
    end
    rd_req_i = 1'b0;
    n_cmp++;
    if (accepted != 12 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL b2b_drain: got %0d accepted %0d outstanding required 12 and 0", accepted, exp_q.size());
    end
    n_cmp++;
    if (b2b == 0) begin
      n_err++;
      $display("FAIL b2b_overlap: got %0d accepts in a vld cycle required at least 1", b2b);
    end
  endtask

  task automatic test_mid_reset();
    int t_acc, t_vld, ack_cyc, vld_seen;
    logic ack_csb;
    logic [XLEN-1:0] d1, d2;
    do_write(12, 32'hA5A5A5A5, ack_cyc, ack_csb);
    rd_req_i = 1'b1; rd_use_rs1_i = 1'b1; rd_use_rs2_i = 1'b0; rd_rs1_addr_i = 5'd12;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (rd_rdy_o === 1'b1) break;
      tick();
    end
    tick();
    rst = 1'b1; rd_req_i = 1'b0;
    #1;
    n_cmp++;
    if ({rd_vld_o, rd_rdy_o, init_done_o, sram_csb_o, sram_web_o} !== 5'b00011 || {rs1_data_o, rs2_data_o} !== '0) begin
      n_err++;
      $display("FAIL midrst_outputs: got vld/rdy/done/csb/web=%b rs1=%h required 00011 and 0",
               {rd_vld_o, rd_rdy_o, init_done_o, sram_csb_o, sram_web_o}, rs1_data_o);
    end
    vld_seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      if (rd_vld_o !== 1'b0) vld_seen++;
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    #1;
    n_cmp++;
    if ({sram_csb_o, sram_web_o, sram_addr_o} !== {2'b00, {AW{1'b0}}}) begin
      n_err++;
      $display("FAIL midrst_init_restart: got csb=%b web=%b addr=%0d required 0 0 0", sram_csb_o, sram_web_o, sram_addr_o);
    end
    for (int i = 1; i < DEPTH; i++) begin
      tick(); #1;
      if (rd_vld_o !== 1'b0) vld_seen++;
    end
    n_cmp++;
    if (vld_seen != 0) begin
      n_err++;
      $display("FAIL midrst_no_vld: got %0d rd_vld_o cycles required 0", vld_seen);
    end
    tick(); #1;
    n_cmp++;
    if (init_done_o !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_init_done: got %b required 1", init_done_o);
    end
    tick();
    do_read(12, 1, 0, 0, 0, 0, '0, t_acc, t_vld, d1, d2);
    n_cmp++;
    if (d1 !== model_rd(12, 1)) begin
      n_err++;
      $display("FAIL midrst_reread: got %h required %h", d1, model_rd(12, 1));
    end
  endtask

  // Test sequence and final report.
  initial begin
    test_reset();
    test_init();
    test_write_read();
    test_same_addr();
    test_zero_reg();
    test_write_priority();
    test_back_to_back();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
